// File: rtl/stream_deskew_pkg.sv
// Shared definitions for the two-lane stream deskew block.
package deskew_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_deskew_if.sv
// Lane inputs, aligned-pair output handshake and status of the deskew block.
interface stream_deskew_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 4
);
  logic                  flush;
  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [CNT_W-1:0]      level_a;
  logic [CNT_W-1:0]      level_b;
  logic                  ovf;

  modport master (
    output flush, a_valid, a_data, b_valid, b_data, out_ready,
    input  out_valid, out_a, out_b, level_a, level_b, ovf
  );

  modport slave (
    input  flush, a_valid, a_data, b_valid, b_data, out_ready,
    output out_valid, out_a, out_b, level_a, level_b, ovf
  );
endinterface

// File: rtl/stream_deskew_lane_fifo.sv
// First-word-fall-through lane buffer; a write is visible at the head one cycle later.
module deskew_lane_fifo
  import deskew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_W-1:0]      level_o,
  output logic                  full_o,
  output logic                  drop_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic                  do_wr, do_rd;

  assign full_o  = (level_q == CNT_W'(DEPTH));
  assign do_rd   = rd_en_i && (level_q != '0);
  // A full lane still accepts a write when its head leaves in the same cycle.
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign drop_o  = wr_en_i && full_o && !do_rd && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/stream_deskew.sv
// Joins two skewed sample lanes and emits matched pairs on a valid/ready output.
module stream_deskew
  import deskew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input logic           clk,
  input logic           rst,
  stream_deskew_if.slave dsk
);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("stream_deskew: DEPTH must be a power of 2 and >= 2");
  end

  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic [CNT_W-1:0]      lvl_a, lvl_b;
  logic                  full_a, full_b, drop_a, drop_b;
  logic                  pair_vld, pop;
  logic                  ovf_q, ovf_d;

  assign pair_vld = (lvl_a != '0) && (lvl_b != '0);
  assign pop      = pair_vld && dsk.out_ready;

  deskew_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_a (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (dsk.flush),
    .wr_en_i   (dsk.a_valid),
    .wr_data_i (dsk.a_data),
    .rd_en_i   (pop),
    .head_o    (head_a),
    .level_o   (lvl_a),
    .full_o    (full_a),
    .drop_o    (drop_a)
  );

  deskew_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_b (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (dsk.flush),
    .wr_en_i   (dsk.b_valid),
    .wr_data_i (dsk.b_data),
    .rd_en_i   (pop),
    .head_o    (head_b),
    .level_o   (lvl_b),
    .full_o    (full_b),
    .drop_o    (drop_b)
  );

  assign ovf_d = ovf_q || drop_a || drop_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign dsk.out_valid = pair_vld;
  assign dsk.out_a     = pair_vld ? head_a : '0;
  assign dsk.out_b     = pair_vld ? head_b : '0;
  assign dsk.level_a   = lvl_a;
  assign dsk.level_b   = lvl_b;
  assign dsk.ovf       = ovf_q;
endmodule

// File: tb/tb_stream_deskew.sv
// Scoreboard bench for stream_deskew: per-lane expected queues checked every cycle.
module tb_stream_deskew;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_deskew_if #(.DATA_WIDTH(DW), .CNT_W(CW)) dsk ();

  stream_deskew #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .dsk (dsk)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic vld;
    vld = (qa.size() != 0) && (qb.size() != 0);
    chk("out_valid", 32'(dsk.out_valid), 32'(vld));
    chk("level_a", 32'(dsk.level_a), 32'(qa.size()));
    chk("level_b", 32'(dsk.level_b), 32'(qb.size()));
    chk("ovf", 32'(dsk.ovf), 32'(exp_ovf));
    if (vld) begin
      chk("out_a", 32'(dsk.out_a), 32'(qa[0]));
      chk("out_b", 32'(dsk.out_b), 32'(qb[0]));
    end else begin
      chk("out_a_zero", 32'(dsk.out_a), 32'd0);
      chk("out_b_zero", 32'(dsk.out_b), 32'd0);
    end
  endtask

  // One cycle: check the current state, drive inputs, advance model, cross the edge.
  task automatic step(input logic av, input logic [DW-1:0] ad,
                      input logic bv, input logic [DW-1:0] bd,
                      input logic rdy, input logic fl);
    logic pop, full_a, full_b;
    check_outputs();
    dsk.a_valid   = av;
    dsk.a_data    = ad;
    dsk.b_valid   = bv;
    dsk.b_data    = bd;
    dsk.out_ready = rdy;
    dsk.flush     = fl;
    pop    = (qa.size() != 0) && (qb.size() != 0) && rdy;
    full_a = (qa.size() == DEPTH);
    full_b = (qb.size() == DEPTH);
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (av) begin
        if (!full_a || pop) qa.push_back(ad);
        else exp_ovf = 1'b1;
      end
      if (bv) begin
        if (!full_b || pop) qb.push_back(bd);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    dsk.flush = 1'b0; dsk.a_valid = 1'b0; dsk.a_data = '0;
    dsk.b_valid = 1'b0; dsk.b_data = '0; dsk.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero skew
    for (int unsigned i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, DW'(i), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Skew of three cycles, B late
    for (int unsigned i = 0; i < 3; i++) step(1'b1, DW'(10 + i), 1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, '0, 1'b1, DW'(10 + i), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Overflow: nine A writes, no B
    for (int unsigned i = 0; i < 9; i++) step(1'b1, DW'(20 + i), 1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Flush mid-stream with ovf set; same-cycle writes discarded
    step(1'b0, '0, 1'b1, 8'd40, 1'b1, 1'b0);
    step(1'b1, 8'd41, 1'b1, 8'd42, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Backpressure: four stalled cycles with both lanes filling, then drain
    for (int unsigned i = 0; i < 4; i++) step(1'b1, DW'(60 + i), 1'b1, DW'(70 + i), 1'b0, 1'b0);
    step(1'b1, 8'd64, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'd74, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Asynchronous reset between edges
    step(1'b1, 8'd80, 1'b1, 8'd81, 1'b0, 1'b0);
    dsk.a_valid = 1'b0; dsk.b_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    qa.delete(); qb.delete(); exp_ovf = 1'b0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full lane A: write accepted in the cycle it pops
    for (int unsigned i = 0; i < DEPTH; i++) step(1'b1, DW'(30 + i), 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 8'd50, 1'b1, 1'b0);
    step(1'b1, 8'd38, 1'b1, 8'd51, 1'b1, 1'b0);
    for (int unsigned i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, DW'(52 + i), 1'b1, 1'b0);
    idle(3, 1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end
endmodule
